// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders + OR)
// adds two N-bit operands LSB first, one bit per clock, with start/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state, state_next;
    logic [N-1:0]   ra, rb, rs, rs_next;
    logic           c;
    logic [CW-1:0]  cnt;
    logic           p, g1, s, g2, carry_next, last;

    half_adder u_ha0 (.x(ra[0]), .y(rb[0]), .s(p), .c(g1));
    half_adder u_ha1 (.x(p),     .y(c),     .s(s), .c(g2));

    assign carry_next = g1 | g2;
    // New sum bit enters at the MSB; after N shifts bit 0 of the sum sits at rs[0].
    assign rs_next    = N'({s, rs} >> 1);
    assign last       = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        c   <= cin;
                        cnt <= '0;
                        rs  <= '0;
                    end
                end
                ADD: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    c   <= carry_next;
                    rs  <= rs_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        sum  <= rs_next;
                        cout <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule
